// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl_if
// Description : Bundle of the fetch controller's bus signals: shared adder
//               operands/result, instruction-memory request/response,
//               decode hand-off and branch/jump redirect.
//   master : the fetch controller (drives adder operands, imem request,
//            decode outputs; receives sum, imem response, id_ready, redirect)
//   slave  : the surrounding core (adder, memory, decode, branch unit)
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  // shared adder
  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic            add_cin;
  logic [XLEN-1:0] add_sum;
  // instruction memory
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  // decode hand-off
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;
  // redirect
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output add_a, add_b, add_cin, imem_req, imem_addr,
           if_valid, if_pc, if_instr,
    input  add_sum, imem_ready, imem_rvalid, imem_rdata,
           id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  add_a, add_b, add_cin, imem_req, imem_addr,
           if_valid, if_pc, if_instr,
    output add_sum, imem_ready, imem_rvalid, imem_rdata,
           id_ready, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program counter and single-outstanding instruction fetch
//               controller. Holds the PC, issues one imem request at a time,
//               buffers the returned instruction for decode and uses the
//               shared adder (PC + 4) for the sequential next PC.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - pc_fetch_ctrl_if.master (adder, imem, decode,
//                        redirect signals)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_imem_req;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_instr;

  // Redirect targets are always word aligned.
  logic [XLEN-1:0] w_redirect_pc;
  assign w_redirect_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.add_a     = r_pc;
  assign bus.add_b     = XLEN'(4);
  assign bus.add_cin   = 1'b0;
  assign bus.imem_addr = r_pc;
  assign bus.imem_req  = r_imem_req;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_instr  = r_if_instr;

  // imem_req and if_valid are registered alongside every state change so
  // that they are high exactly while the FSM sits in REQ / HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_imem_req <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      case (r_state)
        // Any response seen here belongs to a request issued before reset.
        IDLE: begin
          if (bus.redirect_valid) r_pc <= w_redirect_pc;
          r_state    <= REQ;
          r_imem_req <= 1'b1;
        end

        REQ: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
            // Accepted request was for the old PC: its response must be dropped.
            if (bus.imem_ready) begin
              r_state    <= DROP;
              r_imem_req <= 1'b0;
            end
          end else if (bus.imem_ready) begin
            r_state    <= WAIT;
            r_imem_req <= 1'b0;
          end
        end

        WAIT: begin
          if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (bus.imem_rvalid) begin
              r_state    <= REQ;
              r_imem_req <= 1'b1;
            end else begin
              r_state <= DROP;
            end
          end else if (bus.imem_rvalid) begin
            r_if_instr <= bus.imem_rdata;
            r_if_pc    <= r_pc;
            r_state    <= HOLD;
            r_if_valid <= 1'b1;
          end
        end

        HOLD: begin
          if (bus.redirect_valid || bus.id_ready) begin
            r_pc       <= bus.redirect_valid ? w_redirect_pc : bus.add_sum;
            r_state    <= REQ;
            r_imem_req <= 1'b1;
            r_if_valid <= 1'b0;
          end
        end

        DROP: begin
          if (bus.redirect_valid) r_pc <= w_redirect_pc;
          if (bus.imem_rvalid) begin
            r_state    <= REQ;
            r_imem_req <= 1'b1;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Self-checking bench for pc_fetch_ctrl. A transaction-level
//               model (idle / outstanding / killed / held flags) predicts
//               every output each cycle; directed scenarios are followed by
//               a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.XLEN(32)) bus ();

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External shared adder; carry-out is not used.
  assign bus.add_sum = bus.add_a + bus.add_b + {31'b0, bus.add_cin};

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  bit          m_idle;
  bit          m_out;       // a request has been accepted, response pending
  bit          m_kill;      // pending response must be discarded
  bit          m_hold;      // instruction presented to decode
  logic [31:0] m_pc;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_instr;
  logic [31:0] m_req_addr;
  int          m_lat;       // cycles before the memory answers
  int          g_lat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_out = 0; m_kill = 0; m_hold = 0;
    m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = 32'h0;
    m_req_addr = 32'h0; m_lat = 0;
  endtask

  task automatic model_step(input logic rdy, rv, input logic [31:0] rd,
                            input logic idr, rdv, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = rpc & 32'hFFFF_FFFC;
    if (m_idle) begin
      if (rdv) m_pc = tgt;
      m_idle = 0;
    end else if (m_hold) begin
      if (rdv) begin
        m_pc = tgt; m_hold = 0;
      end else if (idr) begin
        m_pc = m_pc + 32'd4; m_hold = 0;
      end
    end else if (m_out) begin
      if (rv) begin
        m_out = 0;
        if (!m_kill && !rdv) begin
          m_hold = 1; m_if_pc = m_pc; m_if_instr = rd;
        end
        m_kill = 0;
      end else begin
        if (m_lat > 0) m_lat--;
        if (rdv) m_kill = 1;
      end
      if (rdv) m_pc = tgt;
    end else begin
      if (rdy) begin
        m_out = 1; m_kill = rdv; m_req_addr = m_pc; m_lat = g_lat;
      end
      if (rdv) m_pc = tgt;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_req",  {31'b0, bus.imem_req}, {31'b0, !m_idle && !m_out && !m_hold});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("add_a",     bus.add_a, m_pc);
    chk("add_b",     bus.add_b, 32'd4);
    chk("add_cin",   {31'b0, bus.add_cin}, 32'd0);
    chk("if_valid",  {31'b0, bus.if_valid}, {31'b0, m_hold});
    chk("if_pc",     bus.if_pc, m_if_pc);
    chk("if_instr",  bus.if_instr, m_if_instr);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic apply(input logic rdy, rv, input logic [31:0] rd,
                       input logic idr, rdv, input logic [31:0] rpc);
    bus.imem_ready     = rdy;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rd;
    bus.id_ready       = idr;
    bus.redirect_valid = rdv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    model_step(rdy, rv, rd, idr, rdv, rpc);
    @(negedge clk);
    check_all();
  endtask

  // Memory answers exactly once per accepted request after m_lat cycles.
  task automatic mem_cycle(input logic rdy, idr, rdv, input logic [31:0] rpc);
    logic rv;
    rv = m_out && (m_lat == 0);
    apply(rdy, rv, rv ? mem_word(m_req_addr) : $urandom, idr, rdv, rpc);
  endtask

  initial begin
    bus.imem_ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.id_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    model_reset();

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // ---- 1: first fetch, 1-cycle memory ----
    g_lat = 0;
    mem_cycle(1, 1, 0, 0);
    chk("t1_req", {31'b0, bus.imem_req}, 32'd1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    mem_cycle(1, 1, 0, 0);
    mem_cycle(1, 1, 0, 0);
    chk("t1_valid", {31'b0, bus.if_valid}, 32'd1);
    chk("t1_instr", bus.if_instr, 32'h0050_0093);
    chk("t1_add_a", bus.add_a, 32'h0);
    mem_cycle(1, 1, 0, 0);
    chk("t1_next_addr", bus.imem_addr, 32'h4);

    // ---- 2: decode stall while holding PC 8 ----
    for (int i = 0; i < 40 && !(m_hold && m_pc == 32'h8); i++) mem_cycle(1, 1, 0, 0);
    chk("t2_reach", {31'b0, m_hold && m_pc == 32'h8}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      mem_cycle(1, 0, 0, 0);
      chk("t2_stall_req", {31'b0, bus.imem_req}, 32'd0);
      chk("t2_stall_pc", bus.if_pc, 32'h8);
    end
    mem_cycle(1, 1, 0, 0);
    chk("t2_next_addr", bus.imem_addr, 32'hC);

    // ---- 3: redirect during WAIT at PC 16 ----
    g_lat = 2;
    for (int i = 0; i < 40 && !(m_out && !m_kill && m_pc == 32'h10); i++) mem_cycle(1, 1, 0, 0);
    chk("t3_reach", {31'b0, m_out && m_pc == 32'h10}, 32'd1);
    mem_cycle(1, 1, 1, 32'h0000_0103);
    for (int i = 0; i < 40 && !(!m_out && !m_hold); i++) mem_cycle(1, 1, 0, 0);
    chk("t3_redir_addr", bus.imem_addr, 32'h100);
    chk("t3_no_leak", bus.if_pc, 32'hC);

    // ---- 4: redirect together with rvalid in WAIT ----
    g_lat = 1;
    for (int i = 0; i < 40 && !(m_out && m_lat == 0); i++) mem_cycle(1, 1, 0, 0);
    chk("t4_reach", {31'b0, m_out && m_lat == 0}, 32'd1);
    mem_cycle(1, 1, 1, 32'h0000_0200);
    chk("t4_req", {31'b0, bus.imem_req}, 32'd1);
    chk("t4_addr", bus.imem_addr, 32'h200);
    chk("t4_valid", {31'b0, bus.if_valid}, 32'd0);

    // ---- 5: PC wraps past 0xFFFF_FFFC ----
    g_lat = 0;
    mem_cycle(0, 1, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 40 && !(m_hold && m_pc == 32'hFFFF_FFFC); i++) mem_cycle(1, 0, 0, 0);
    chk("t5_reach", bus.if_pc, 32'hFFFF_FFFC);
    mem_cycle(1, 1, 0, 0);
    chk("t5_wrap_addr", bus.imem_addr, 32'h0);

    // ---- 6: reset mid-WAIT, stale response in IDLE ----
    g_lat = 3;
    for (int i = 0; i < 40 && !m_out; i++) mem_cycle(1, 1, 0, 0);
    chk("t6_reach", {31'b0, m_out}, 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
    chk("t6_req", {31'b0, bus.imem_req}, 32'd1);
    chk("t6_addr", bus.imem_addr, 32'h0);
    chk("t6_valid", {31'b0, bus.if_valid}, 32'd0);

    // ---- randomized phase ----
    for (int i = 0; i < 600; i++) begin
      logic        rdy, idr, rdv;
      logic [31:0] rpc;
      g_lat = $urandom_range(0, 3);
      rdy = ($urandom_range(0, 9) < 7);
      idr = ($urandom_range(0, 9) < 6);
      rdv = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : $urandom;
      mem_cycle(rdy, idr, rdv, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
